// File: rtl/fetch_unit.sv
// Fetch unit: assembles a 16-bit instruction from two byte reads, keeps the
// program counter and a sticky halt flag, and selects the memory address
// between the program counter and the instruction operand field.
module fetch_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  data,
  input  logic        load_ir,
  input  logic        inc_pc,
  input  logic        load_pc,
  input  logic        halt,
  input  logic        fetch,
  output logic [2:0]  opcode,
  output logic [12:0] ir_addr,
  output logic [12:0] pc_addr,
  output logic [12:0] addr,
  output logic        ir_valid,
  output logic        halted
);

  logic [15:0] ir_q, ir_d;
  logic        bp_q, bp_d;
  logic [12:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic        halted_q, halted_d;

  // Next-state logic: byte capture, PC update and halt latch; a set halt flag freezes everything but itself
  always_comb begin
    ir_d     = ir_q;
    bp_d     = bp_q;
    pc_d     = pc_q;
    valid_d  = valid_q;
    halted_d = halted_q | halt;
    if (!halted_q) begin
      if (load_ir) begin
        if (!bp_q) begin
          ir_d[15:8] = data;
          bp_d       = 1'b1;
          valid_d    = 1'b0;
        end else begin
          ir_d[7:0]  = data;
          bp_d       = 1'b0;
          valid_d    = 1'b1;
        end
      end else begin
        bp_d = 1'b0;
      end
      if (load_pc) begin
        pc_d = ir_q[12:0];
      end else if (inc_pc) begin
        pc_d = pc_q + 13'd1;
      end
    end
  end

  // State registers with immediate clearing while reset is held low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_q     <= 16'h0000;
      bp_q     <= 1'b0;
      pc_q     <= 13'h0000;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      ir_q     <= ir_d;
      bp_q     <= bp_d;
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
    end
  end

  // Outputs come straight from registers; only fetch steers the address mux combinationally
  always_comb begin
    opcode   = ir_q[15:13];
    ir_addr  = ir_q[12:0];
    pc_addr  = pc_q;
    ir_valid = valid_q;
    halted   = halted_q;
    addr     = fetch ? pc_q : ir_q[12:0];
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized
// strobes compared against an instruction-level reference model.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [7:0]  data;
  logic        load_ir;
  logic        inc_pc;
  logic        load_pc;
  logic        halt;
  logic        fetch;
  logic [2:0]  opcode;
  logic [12:0] ir_addr;
  logic [12:0] pc_addr;
  logic [12:0] addr;
  logic        ir_valid;
  logic        halted;

  int checkCount = 0;
  int failCount  = 0;

  // Reference model state, kept as plain integers and a pending-byte flag
  int  mHigh;
  int  mLow;
  bit  mPending;
  int  mPc;
  bit  mValid;
  bit  mHalted;

  fetch_unit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .data     (data),
    .load_ir  (load_ir),
    .inc_pc   (inc_pc),
    .load_pc  (load_pc),
    .halt     (halt),
    .fetch    (fetch),
    .opcode   (opcode),
    .ir_addr  (ir_addr),
    .pc_addr  (pc_addr),
    .addr     (addr),
    .ir_valid (ir_valid),
    .halted   (halted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic int modelIr();
    return mHigh * 256 + mLow;
  endfunction

  task automatic modelReset();
    mHigh = 0; mLow = 0; mPending = 0; mPc = 0; mValid = 0; mHalted = 0;
  endtask

  // One clock edge of the model, using the strobes currently on the inputs
  task automatic modelStep();
    int oldOperand;
    oldOperand = modelIr() % 8192;
    if (!mHalted) begin
      if (load_ir) begin
        if (!mPending) begin
          mHigh = int'(data); mPending = 1; mValid = 0;
        end else begin
          mLow = int'(data); mPending = 0; mValid = 1;
        end
      end else begin
        mPending = 0;
      end
      if (load_pc)     mPc = oldOperand;
      else if (inc_pc) mPc = (mPc + 1) % 8192;
    end
    if (halt) mHalted = 1;
  endtask

  task automatic compareAll(input string tag);
    int irVal;
    irVal = modelIr();
    checkOutput({tag, ".opcode"},  32'(opcode),   32'(irVal / 8192));
    checkOutput({tag, ".ir_addr"}, 32'(ir_addr),  32'(irVal % 8192));
    checkOutput({tag, ".pc_addr"}, 32'(pc_addr),  32'(mPc));
    checkOutput({tag, ".addr"},    32'(addr),     32'(fetch ? mPc : irVal % 8192));
    checkOutput({tag, ".valid"},   32'(ir_valid), 32'(mValid));
    checkOutput({tag, ".halted"},  32'(halted),   32'(mHalted));
  endtask

  // Drive one cycle of strobes, clock it, then check away from the edge
  task automatic applyStimulus(input bit li, input logic [7:0] d, input bit inc, input bit lpc,
                               input bit h, input bit f, input string tag);
    load_ir = li; data = d; inc_pc = inc; load_pc = lpc; halt = h; fetch = f;
    @(posedge clk);
    modelStep();
    @(negedge clk);
    compareAll(tag);
  endtask

  task automatic loadInstr(input logic [7:0] hi, input logic [7:0] lo, input string tag);
    applyStimulus(1, hi, 0, 0, 0, 1, {tag, ".hi"});
    applyStimulus(1, lo, 0, 0, 0, 1, {tag, ".lo"});
  endtask

  // Assert reset a few time units after a rising edge and check outputs without a clock edge
  task automatic midCycleReset(input string tag);
    load_ir = 0; inc_pc = 0; load_pc = 0; halt = 0; fetch = 1;
    @(posedge clk);
    modelStep();
    #3 rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput({tag, ".opcode"},  32'(opcode),   32'h0);
    checkOutput({tag, ".ir_addr"}, 32'(ir_addr),  32'h0);
    checkOutput({tag, ".pc_addr"}, 32'(pc_addr),  32'h0);
    checkOutput({tag, ".addr"},    32'(addr),     32'h0);
    checkOutput({tag, ".valid"},   32'(ir_valid), 32'h0);
    checkOutput({tag, ".halted"},  32'(halted),   32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [12:0] savedPc;
    logic [12:0] savedIrAddr;
    logic [2:0]  savedOp;

    rst_n = 1'b0; data = 8'h00; load_ir = 0; inc_pc = 0; load_pc = 0; halt = 0; fetch = 1;
    modelReset();
    #2;
    compareAll("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Two-byte fetch
    loadInstr(8'hA1, 8'h23, "twoByte");
    checkOutput("twoByte.opcodeConst", 32'(opcode), 32'h5);
    checkOutput("twoByte.irAddrConst", 32'(ir_addr), 32'h0123);
    checkOutput("twoByte.validConst", 32'(ir_valid), 32'h1);

    // Increment and wrap
    loadInstr(8'h1F, 8'hFE, "wrapSetup");
    applyStimulus(0, 8'h00, 0, 1, 0, 1, "wrapLoad");
    checkOutput("wrapLoad.pcConst", 32'(pc_addr), 32'h1FFE);
    applyStimulus(0, 8'h00, 1, 0, 0, 1, "wrapInc1");
    checkOutput("wrapInc1.pcConst", 32'(pc_addr), 32'h1FFF);
    applyStimulus(0, 8'h00, 1, 0, 0, 1, "wrapInc2");
    checkOutput("wrapInc2.pcConst", 32'(pc_addr), 32'h0000);

    // Jump has priority over increment
    loadInstr(8'h01, 8'h55, "jumpSetup");
    applyStimulus(0, 8'h00, 1, 1, 0, 1, "jumpPrio");
    checkOutput("jumpPrio.pcConst", 32'(pc_addr), 32'h0155);

    // Abandoned high byte
    applyStimulus(1, 8'hFF, 0, 0, 0, 1, "abandonHi");
    checkOutput("abandonHi.validConst", 32'(ir_valid), 32'h0);
    applyStimulus(0, 8'h00, 0, 0, 0, 1, "abandonIdle");
    checkOutput("abandonIdle.validConst", 32'(ir_valid), 32'h0);
    loadInstr(8'h40, 8'h05, "abandonFull");
    checkOutput("abandonFull.irConst", 32'({opcode, ir_addr}), 32'h4005);
    checkOutput("abandonFull.opConst", 32'(opcode), 32'h2);

    // Address mux, fetch toggled within one cycle
    loadInstr(8'h00, 8'h10, "muxPc");
    applyStimulus(0, 8'h00, 0, 1, 0, 1, "muxLoad");
    loadInstr(8'h1A, 8'hBC, "muxIr");
    fetch = 1; #1 checkOutput("mux.fetch1", 32'(addr), 32'h0010);
    fetch = 0; #1 checkOutput("mux.fetch0", 32'(addr), 32'h1ABC);
    fetch = 1; #1 checkOutput("mux.fetch1b", 32'(addr), 32'h0010);

    // Reset between the two byte captures discards the partial instruction
    applyStimulus(1, 8'h77, 0, 0, 0, 1, "partialHi");
    midCycleReset("partialReset");
    loadInstr(8'h9C, 8'h3D, "afterReset");
    checkOutput("afterReset.irConst", 32'({opcode, ir_addr}), 32'h9C3D);

    // Randomized strobes without halt
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0),
                    0, 1'($urandom), "rand");
    end

    // Halt: the halting edge still applies strobes, later edges are frozen
    applyStimulus(1, 8'($urandom), 1, 0, 1, 1, "haltEdge");
    checkOutput("haltEdge.haltedConst", 32'(halted), 32'h1);
    savedPc = pc_addr; savedIrAddr = ir_addr; savedOp = opcode;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 8'($urandom), 1, 0, 0, 1, "frozen");
    end
    checkOutput("frozen.pcHeld", 32'(pc_addr), 32'(savedPc));
    checkOutput("frozen.irHeld", 32'({opcode, ir_addr}), 32'({savedOp, savedIrAddr}));
    checkOutput("frozen.haltedConst", 32'(halted), 32'h1);
    midCycleReset("haltReset");
    compareAll("haltReleased");

    // Randomized strobes with occasional halt and reset
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) midCycleReset("randReset");
      applyStimulus(1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 49) == 0),
                    1'($urandom), "randHalt");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have port clk, input, 1, single system clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-003 SHALL have port data, input, 8, memory read byte, valid while load_ir=1.
REQ-004 SHALL have port load_ir, input, 1, controller strobe: capture one instruction byte this cycle.
REQ-005 SHALL have port inc_pc, input, 1, controller strobe: advance program counter by 1.
REQ-006 SHALL have port load_pc, input, 1, controller strobe: load program counter from ir_addr.
REQ-007 SHALL have port halt, input, 1, controller halt indication.
REQ-008 SHALL have port fetch, input, 1, address-select phase: 1 = instruction fetch, 0 = operand access.
REQ-009 SHALL have port opcode, output, 3, instruction opcode = ir[15:13].
REQ-010 SHALL have port ir_addr, output, 13, instruction operand address = ir[12:0].
REQ-011 SHALL have port pc_addr, output, 13, program counter value.
REQ-012 SHALL have port addr, output, 13, memory address bus.
REQ-013 SHALL have port ir_valid, output, 1, complete 16-bit instruction held in ir.
REQ-014 SHALL have port halted, output, 1, sticky halt status.

Function
REQ-015 SHALL hold a 16-bit instruction register ir, a 1-bit byte pointer bp (0 = high byte next), a 13-bit PC, and a sticky halted flag.
REQ-016 SHALL, on a rising edge with load_ir=1, halted=0 and bp=0, write data into ir[15:8], set bp=1, and clear ir_valid.
REQ-017 SHALL, on a rising edge with load_ir=1, halted=0 and bp=1, write data into ir[7:0], set bp=0, and set ir_valid=1.
REQ-018 SHALL, on a rising edge with load_ir=0, force bp=0; a lone high-byte capture is abandoned, and ir_valid stays 0 until a full two-byte capture completes.
REQ-019 SHALL leave ir[7:0] unchanged on a high-byte capture and ir[15:8] unchanged on a low-byte capture.
REQ-020 SHALL drive opcode and ir_addr combinationally from ir; both change the cycle after each byte capture.
REQ-021 SHALL, on a rising edge with load_pc=1 and halted=0, load PC with ir_addr, using the ir value before that edge.
REQ-022 SHALL, on a rising edge with inc_pc=1, load_pc=0 and halted=0, set PC to PC+1 modulo 2^13, so 0x1FFF wraps to 0x0000.
REQ-023 SHALL give load_pc priority over inc_pc when both are 1 on the same edge; no increment occurs.
REQ-024 SHALL hold PC when neither load_pc nor inc_pc is 1.
REQ-025 SHALL set halted on the first rising edge with halt=1; halted stays 1 until rst_n is asserted.
REQ-026 SHALL, while halted=1, ignore load_ir, inc_pc and load_pc; ir, bp, PC and ir_valid hold their values.
REQ-027 SHALL, on an edge where halt first goes to 1, still apply that edge's inc_pc, load_pc and load_ir; the freeze starts on the following edge.
REQ-028 SHALL drive addr = pc_addr when fetch=1 and addr = ir_addr when fetch=0; the select is combinational, with no added latency.
REQ-029 SHALL have no combinational path from data, load_ir, inc_pc, load_pc or halt to any output; the only combinational path is fetch to addr.

Reset
REQ-030 SHALL, while rst_n=0, immediately and without waiting for clk, force ir=0x0000, bp=0, PC=0x0000, ir_valid=0 and halted=0.
REQ-031 SHALL, as a result of REQ-030, output opcode=3'b000, ir_addr=0x0000, pc_addr=0x0000 and addr=0x0000 during reset.
REQ-032 SHALL respond to strobes starting from the first rising edge after rst_n deasserts, with no extra wait cycles.
REQ-033 SHALL, if rst_n asserts between the two byte captures, discard the partial instruction; after reset the next load_ir byte is treated as a high byte.

Verification
REQ-034 SHALL cover two-byte fetch: load_ir=1 for 2 cycles, data=0xA1 then 0x23 -> opcode=3'b101, ir_addr=0x0123, ir_valid=1 after the second edge.
REQ-035 SHALL cover increment and wrap: PC preset to 0x1FFE by load_pc, then 2 cycles of inc_pc -> pc_addr=0x1FFF then 0x0000.
REQ-036 SHALL cover jump priority: ir_addr=0x0155 with load_pc=1 and inc_pc=1 on the same edge -> pc_addr=0x0155, not 0x0156.
REQ-037 SHALL cover abandoned fetch: load_ir=1 for 1 cycle with data 0xFF, then idle 1 cycle, then 2 cycles with data 0x40, 0x05 -> ir=0x4005 and opcode=3'b010.
REQ-038 SHALL cover halt freeze: halt=1 for 1 cycle, then inc_pc and load_ir held at 1 for 5 cycles -> pc_addr and ir unchanged and halted=1; rst_n pulsed low mid-cycle -> all outputs 0 immediately.
REQ-039 SHALL cover address mux: pc_addr=0x0010 and ir_addr=0x1ABC; toggling fetch 1, 0, 1 -> addr=0x0010, 0x1ABC, 0x0010 within the same cycle.
